// File: rtl/qc_fsm_complex.sv
// Complex-amplitude quantum gate FSM: loads a 2^N complex state and a chain of gates over a
// two-phase GPIO handshake, applies each gate with a sequential complex MAC, streams the result.
module qc_fsm_complex #(
  parameter int unsigned N    = 3,
  parameter int unsigned W    = 16,
  parameter int unsigned FRAC = W - 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_ready,
  input  logic [W-1:0] load_data,
  input  logic         new_gate,
  output logic [W-1:0] send_data,
  output logic         busy,
  output logic         done,
  output logic         sat
);

  localparam int unsigned Max  = 1 << N;
  localparam int unsigned AccW = 2 * W + N + 2;

  localparam logic signed [AccW-1:0] Half   = AccW'(1) << (FRAC - 1);
  localparam logic signed [AccW-1:0] SatMax = {{(AccW - W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [AccW-1:0] SatMin = {{(AccW - W + 1){1'b1}}, {(W - 1){1'b0}}};

  typedef enum logic [3:0] {
    StIdle,
    StLoadState,
    StLoadStateWait,
    StLoadGate,
    StLoadGateWait,
    StMult,
    StCheckRepeat,
    StSend,
    StSendWait
  } state_e;

  state_e state_q, state_d;
  logic [N-1:0] row_q, row_d, col_q, col_d, k_q, k_d;
  logic         part_q, part_d;
  logic signed [AccW-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [W-1:0] send_q, send_d;
  logic         done_q, done_d, sat_q, sat_d;

  // Data arrays carry no reset; only control state is cleared.
  logic signed [W-1:0] st_re_q  [Max];
  logic signed [W-1:0] st_im_q  [Max];
  logic signed [W-1:0] g_re_q   [Max*Max];
  logic signed [W-1:0] g_im_q   [Max*Max];
  logic signed [W-1:0] out_re_q [Max];
  logic signed [W-1:0] out_im_q [Max];

  logic st_we, st_copy, g_we, out_we;

  logic signed [W-1:0]    gr, gi, sr, si;
  logic signed [2*W-1:0]  p_rr, p_ii, p_ri, p_ir;
  logic signed [AccW-1:0] term_re, term_im, sum_re, sum_im, sh_re, sh_im;
  logic [W:0]             cl_re, cl_im;

  // Returns {clamped_flag, W-bit value}.
  function automatic logic [W:0] clamp(input logic signed [AccW-1:0] v);
    if (v > SatMax) begin
      clamp = {2'b10, {(W - 1){1'b1}}};
    end else if (v < SatMin) begin
      clamp = {2'b11, {(W - 1){1'b0}}};
    end else begin
      clamp = {1'b0, v[W-1:0]};
    end
  endfunction

  always_comb begin
    gr      = g_re_q[{row_q, k_q}];
    gi      = g_im_q[{row_q, k_q}];
    sr      = st_re_q[k_q];
    si      = st_im_q[k_q];
    p_rr    = (2*W)'(gr) * (2*W)'(sr);
    p_ii    = (2*W)'(gi) * (2*W)'(si);
    p_ri    = (2*W)'(gr) * (2*W)'(si);
    p_ir    = (2*W)'(gi) * (2*W)'(sr);
    term_re = AccW'(p_rr) - AccW'(p_ii);
    term_im = AccW'(p_ri) + AccW'(p_ir);
    sum_re  = acc_re_q + term_re;
    sum_im  = acc_im_q + term_im;
    sh_re   = (sum_re + Half) >>> FRAC;
    sh_im   = (sum_im + Half) >>> FRAC;
    cl_re   = clamp(sh_re);
    cl_im   = clamp(sh_im);
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    k_d      = k_q;
    part_d   = part_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    send_d   = send_q;
    done_d   = 1'b0;
    sat_d    = sat_q;
    st_we    = 1'b0;
    st_copy  = 1'b0;
    g_we     = 1'b0;
    out_we   = 1'b0;

    unique case (state_q)
      StIdle: begin
        row_d    = '0;
        col_d    = '0;
        k_d      = '0;
        part_d   = 1'b0;
        acc_re_d = '0;
        acc_im_d = '0;
        sat_d    = 1'b0;
        state_d  = StLoadState;
      end
      StLoadState: begin
        if (load_ready) begin
          st_we   = 1'b1;
          state_d = StLoadStateWait;
        end
      end
      StLoadStateWait: begin
        if (!load_ready) begin
          part_d  = ~part_q;
          state_d = StLoadState;
          if (part_q) begin
            col_d = col_q + 1'b1;
            if (col_q == N'(Max - 1)) state_d = StLoadGate;
          end
        end
      end
      StLoadGate: begin
        if (load_ready) begin
          g_we    = 1'b1;
          state_d = StLoadGateWait;
        end
      end
      StLoadGateWait: begin
        if (!load_ready) begin
          part_d  = ~part_q;
          state_d = StLoadGate;
          if (part_q) begin
            col_d = col_q + 1'b1;
            if (col_q == N'(Max - 1)) begin
              row_d = row_q + 1'b1;
              if (row_q == N'(Max - 1)) begin
                k_d     = '0;
                state_d = StMult;
              end
            end
          end
        end
      end
      StMult: begin
        if (k_q == N'(Max - 1)) begin
          out_we   = 1'b1;
          sat_d    = sat_q | cl_re[W] | cl_im[W];
          acc_re_d = '0;
          acc_im_d = '0;
          k_d      = '0;
          row_d    = row_q + 1'b1;
          if (row_q == N'(Max - 1)) state_d = StCheckRepeat;
        end else begin
          acc_re_d = sum_re;
          acc_im_d = sum_im;
          k_d      = k_q + 1'b1;
        end
      end
      StCheckRepeat: begin
        if (new_gate) begin
          st_copy = 1'b1;
          state_d = StLoadGate;
        end else begin
          state_d = StSend;
        end
      end
      StSend: begin
        if (load_ready) begin
          send_d  = part_q ? out_im_q[col_q] : out_re_q[col_q];
          state_d = StSendWait;
        end
      end
      StSendWait: begin
        if (!load_ready) begin
          part_d  = ~part_q;
          state_d = StSend;
          if (part_q) begin
            col_d = col_q + 1'b1;
            if (col_q == N'(Max - 1)) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      row_q    <= '0;
      col_q    <= '0;
      k_q      <= '0;
      part_q   <= 1'b0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      send_q   <= '0;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      k_q      <= k_d;
      part_q   <= part_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      send_q   <= send_d;
      done_q   <= done_d;
      sat_q    <= sat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (st_we) begin
      if (part_q) st_im_q[col_q] <= load_data;
      else        st_re_q[col_q] <= load_data;
    end
    if (st_copy) begin
      for (int unsigned i = 0; i < Max; i++) begin
        st_re_q[i] <= out_re_q[i];
        st_im_q[i] <= out_im_q[i];
      end
    end
    if (g_we) begin
      if (part_q) g_im_q[{row_q, col_q}] <= load_data;
      else        g_re_q[{row_q, col_q}] <= load_data;
    end
    if (out_we) begin
      out_re_q[row_q] <= cl_re[W-1:0];
      out_im_q[row_q] <= cl_im[W-1:0];
    end
  end

  assign send_data = send_q;
  assign busy      = (state_q == StMult) || (state_q == StCheckRepeat);
  assign done      = done_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_qc_fsm_complex.sv
// Directed bench for qc_fsm_complex: one N=1 and one N=2 instance share the handshake,
// selected by sel; expected values are hand-computed in Q2.14.
module tb_qc_fsm_complex;

  typedef logic [15:0] wq_t[$];

  logic        clk = 1'b0;
  logic        reset, lr, new_gate, sel;
  logic [15:0] ld;
  logic [15:0] sd1, sd2, sd;
  logic        busy1, busy2, done1, done2, sat1, sat2;
  logic        busy, done, sat;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int done_cnt = 0, done_base;
  int cyc;

  qc_fsm_complex #(.N(1), .W(16), .FRAC(14)) u_dut1 (
    .clk(clk), .reset(reset), .load_ready(lr & ~sel), .load_data(ld), .new_gate(new_gate),
    .send_data(sd1), .busy(busy1), .done(done1), .sat(sat1)
  );

  qc_fsm_complex #(.N(2), .W(16), .FRAC(14)) u_dut2 (
    .clk(clk), .reset(reset), .load_ready(lr & sel), .load_data(ld), .new_gate(new_gate),
    .send_data(sd2), .busy(busy2), .done(done2), .sat(sat2)
  );

  assign sd   = sel ? sd2 : sd1;
  assign busy = sel ? busy2 : busy1;
  assign done = sel ? done2 : done1;
  assign sat  = sel ? sat2 : sat1;

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put_word(input logic [15:0] d, input int hold, input int gap);
    @(negedge clk);
    lr = 1'b1;
    ld = d;
    repeat (hold) @(negedge clk);
    lr = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic get_word(output logic [15:0] d, input int hold, input int gap);
    @(negedge clk);
    lr = 1'b1;
    @(negedge clk);
    d = sd;
    repeat (hold - 1) @(negedge clk);
    lr = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic put_seq(input wq_t q, input bit rnd);
    foreach (q[i]) put_word(q[i], rnd ? 5 : 1, rnd ? int'($urandom_range(4, 1)) : 1);
  endtask

  task automatic get_seq(input string tag, input wq_t q, input bit rnd);
    logic [15:0] d;
    foreach (q[i]) begin
      get_word(d, rnd ? 5 : 1, rnd ? int'($urandom_range(4, 1)) : 1);
      check($sformatf("%s[%0d]", tag, i), {16'h0, d}, {16'h0, q[i]});
    end
  endtask

  // Counts negedges with busy high; MULT plus the CHECK_REPEAT cycle.
  task automatic wait_mult(output int n);
    n = 0;
    while (busy === 1'b1 && n < 500) begin
      n++;
      @(negedge clk);
    end
    check("mult_timeout", {31'h0, busy}, 32'h0);
  endtask

  wq_t st1, g_had, g_py, st_sat, g_sat, exp_had, exp_py, exp_sat;
  wq_t st2, g_x, exp_x;

  initial begin
    st1     = '{16'h4000, 16'h0000, 16'h0000, 16'h0000};
    g_had   = '{16'h2D41, 16'h0, 16'h2D41, 16'h0, 16'h2D41, 16'h0, 16'hD2BF, 16'h0};
    exp_had = '{16'h2D41, 16'h0000, 16'h2D41, 16'h0000};
    g_py    = '{16'h0, 16'h0, 16'h0, 16'hC000, 16'h0, 16'h4000, 16'h0, 16'h0};
    exp_py  = '{16'h0000, 16'h0000, 16'h0000, 16'h4000};
    st_sat  = '{16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000};
    g_sat   = '{16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h7FFF, 16'h0};
    exp_sat = '{16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000};
    st2     = '{16'h1000, 16'h0100, 16'h2000, 16'hFE00,
                16'h0800, 16'h0040, 16'hF000, 16'h0123};
    exp_x   = '{16'h2000, 16'hFE00, 16'h1000, 16'h0100,
                16'hF000, 16'h0123, 16'h0800, 16'h0040};
    g_x = {};
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        g_x.push_back((c == (r ^ 1)) ? 16'h4000 : 16'h0000);
        g_x.push_back(16'h0000);
      end
    end

    sel = 1'b0; lr = 1'b0; ld = 16'h0; new_gate = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_n1", {12'h0, sd1, busy1, done1, sat1}, 32'h0);
    check("reset_n2", {12'h0, sd2, busy2, done2, sat2}, 32'h0);
    reset = 1'b0;

    // Hadamard, N=1
    done_base = done_cnt;
    put_seq(st1, 1'b0);
    put_seq(g_had, 1'b0);
    wait_mult(cyc);
    check("had_mult_cycles", cyc, 32'd5);
    get_seq("had", exp_had, 1'b0);
    check("had_done", {31'h0, done}, 32'h1);
    check("had_sat", {31'h0, sat}, 32'h0);
    @(negedge clk);
    check("had_done_once", done_cnt - done_base, 32'd1);

    // Pauli-Y, N=1
    put_seq(st1, 1'b0);
    put_seq(g_py, 1'b0);
    wait_mult(cyc);
    get_seq("pauli_y", exp_py, 1'b0);
    check("py_sat", {31'h0, sat}, 32'h0);

    // Saturation, N=1; sat stays until IDLE->LOAD_STATE
    put_seq(st_sat, 1'b0);
    put_seq(g_sat, 1'b0);
    wait_mult(cyc);
    get_seq("sat", exp_sat, 1'b0);
    check("sat_set", {31'h0, sat}, 32'h1);
    @(negedge clk);
    check("sat_cleared", {31'h0, sat}, 32'h0);

    // Handshake robustness: long holds and random gaps, Hadamard again
    done_base = done_cnt;
    put_seq(st1, 1'b1);
    put_seq(g_had, 1'b1);
    wait_mult(cyc);
    get_seq("had_slow", exp_had, 1'b1);
    repeat (2) @(negedge clk);
    check("slow_done_once", done_cnt - done_base, 32'd1);

    // Gate chaining, N=2: X then X returns the input state
    sel = 1'b1;
    new_gate = 1'b1;
    done_base = done_cnt;
    put_seq(st2, 1'b0);
    put_seq(g_x, 1'b0);
    wait_mult(cyc);
    check("chain_mult1_cycles", cyc, 32'd17);
    new_gate = 1'b0;
    put_seq(g_x, 1'b0);
    wait_mult(cyc);
    check("chain_mult2_cycles", cyc, 32'd17);
    get_seq("chain", st2, 1'b0);
    @(negedge clk);
    check("chain_done_once", done_cnt - done_base, 32'd1);

    // Reset during MULT row 1
    check("send_hold", {16'h0, sd}, 32'h0123);
    put_seq(st2, 1'b0);
    put_seq(g_x, 1'b0);
    repeat (5) @(negedge clk);
    check("busy_before_reset", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_send", {16'h0, sd}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    reset = 1'b0;
    put_seq(st2, 1'b0);
    put_seq(g_x, 1'b0);
    wait_mult(cyc);
    check("reload_mult_cycles", cyc, 32'd17);
    get_seq("reload_x", exp_x, 1'b0);
    check("reload_done", {31'h0, done}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/qc_fsm_complex.md
# qc_fsm_complex

Parametrised complex-amplitude successor to the real-only quantum-computer FSM. It loads a 2^N complex state vector and a sequence of 2^N x 2^N complex gates from the MicroBlaze GPIO handshake. Each gate is applied with an internal sequential complex multiply-accumulate, and the final state is streamed back over the same handshake. It sits between the MicroBlaze MCS GPIO ports and the host UART link, and replaces the external combinational multiplier.

## Interface
- N, default 3: qubit count; MAX = 2**N.
- W, default 16: signed fixed-point word width, format Q2.(W-2).
- FRAC, default W-2: fractional bits.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears FSM, indices, accumulators and outputs.
- load_ready  in  1  MicroBlaze handshake level; high means a word is offered or requested, low means acknowledged.
- load_data  in  W  word offered by the MicroBlaze; valid while load_ready is high.
- new_gate  in  1  sampled in CHECK_REPEAT; high means another gate follows.
- send_data  out  W  word returned to the MicroBlaze.
- busy  out  1  high while in MULT or CHECK_REPEAT.
- done  out  1  one-cycle pulse when the last send word is acknowledged.
- sat  out  1  sticky; set by any saturation in MULT, cleared on IDLE->LOAD_STATE.

## Operation
- States: IDLE, LOAD_STATE, LOAD_STATE_WAIT, LOAD_GATE, LOAD_GATE_WAIT, MULT, CHECK_REPEAT, SEND, SEND_WAIT.
- IDLE: clear row, col and part (re/im select); go to LOAD_STATE next cycle; clear sat.
- Every word transfer is a two-phase handshake.
  - Capture state: on a clk edge with load_ready=1, latch load_data and go to the matching WAIT state.
  - WAIT state: on a clk edge with load_ready=0, advance the index and return to the capture state.
- Word order for vectors: for i = 0..MAX-1, re then im.
- Word order for gates: row-major, and within each element re then im.
- State vector: 2*MAX words. After the last im word, go to LOAD_GATE with indices cleared.
- Gate: 2*MAX*MAX words. After the last im word, go to MULT with row=k=0.
- MULT: one complex term per cycle, k inner and row outer; exactly MAX*MAX cycles.
  - term_re = g_re*s_re - g_im*s_im; term_im = g_re*s_im + g_im*s_re.
  - sum = acc + term. Accumulator width is 2W+N+2 bits, signed, with no internal overflow.
  - When k=MAX-1: out[row] = sat(round(sum)), acc cleared. Otherwise acc = sum.
- round: add 1<<(FRAC-1), then arithmetic shift right by FRAC.
- sat: clamp to [-(2^(W-1)), 2^(W-1)-1] and set the sat flag if clamped.
- CHECK_REPEAT (1 cycle):
  - new_gate=1: state <= out, go to LOAD_GATE.
  - new_gate=0: go to SEND.
- SEND/SEND_WAIT: same handshake as loading, streaming out[i].re then out[i].im.
  - Capture edge loads send_data.
  - After the last im word is acknowledged: done=1 for one cycle, go to IDLE.
- state, gate and out arrays are not reset. Only control logic and outputs are reset.

## Timing
- Reset values: FSM=IDLE, row=col=k=part=0, acc=0, send_data=0, busy=0, done=0, sat=0.
- Reset has immediate effect at any point, including mid-load, mid-MULT and mid-send. Partial data is discarded, and the host must restart from the state vector.
- load_ready is synchronous to clk. There is no internal synchroniser.
- Data is captured on the first edge where load_ready=1 in a capture state. Holding load_ready high extra cycles captures once only.
- load_ready high during MULT or CHECK_REPEAT is ignored until the FSM reaches the next capture state.
- Gate latency: the last gate word is acknowledged at edge t, so MULT starts at t+1. CHECK_REPEAT is at t+1+MAX*MAX.
- send_data changes only on capture edges in SEND and holds between them.
- Arithmetic is signed two's complement. Products are 2W bits, and the final result is always exactly W bits.

## Test plan
- Hadamard, N=1: state (0x4000,0),(0,0); gate all 0x2D41 with entries [1][1] = 0xD2BF; new_gate=0 -> send 0x2D41,0,0x2D41,0; sat=0; done pulses once.
- Pauli-Y, N=1: state |0>=(0x4000,0),(0,0); gate [[0,-i],[i,0]] with im words 0xC000 and 0x4000 -> send 0,0,0,0x4000.
- Gate chaining, N=2: X on qubit 0 with new_gate=1, then X again with new_gate=0 -> output equals the loaded input state; MULT lasts exactly 16 cycles per gate.
- Saturation, N=1: all re words 0x7FFF, im 0 -> every out re = 0x7FFF, im = 0, sat=1. The next IDLE->LOAD_STATE transition clears sat.
- Handshake robustness: hold load_ready high 5 cycles per word, with random low gaps of 1-4 cycles -> each word captured exactly once, and results identical to the zero-gap run.
- Reset mid-operation: assert reset during MULT row 1 -> next cycle FSM=IDLE, busy=0, send_data=0. A full reload then produces the correct result.
